// File: rtl/camera_pkg.sv
// Shared camera types and default frame geometry for capture, display and frame-buffer blocks.
package camera_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      SYNC    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } cap_state_t;

   typedef logic [15:0] rgb565_t;

   localparam int unsigned H_RES_DEF    = 640;
   localparam int unsigned V_RES_DEF    = 480;
   localparam int unsigned ADDR_W_DEF   = 19;
   localparam int unsigned DEBOUNCE_DEF = 250000;

   // States in which a capture is pending or in progress.
   function automatic logic is_busy(input cap_state_t s);
      return (s == ARMED) || (s == SYNC) || (s == CAPTURE);
   endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Camera byte stream in, frame-buffer write port out.
interface camera_capture_if
   import camera_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

   logic              href;
   logic              vsync;
   logic [7:0]        d;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   rgb565_t           wr_data;

   // Capture block: consumes camera bytes, produces frame-buffer writes.
   modport master (
      input  href, vsync, d,
      output wr_en, wr_addr, wr_data
   );

   // Environment side: drives camera bytes, sinks frame-buffer writes.
   modport slave (
      output href, vsync, d,
      input  wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/shutter_debounce.sv
// Synchronises and debounces the raw shutter switch; emits a one-cycle pulse per press.
module shutter_debounce
   import camera_pkg::*;
#(
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic shutter_raw,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

   logic             sync_q1;
   logic             sync_q2;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;

   // Two-flop synchroniser, stability counter and debounced level with rising-edge pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         sync_q1 <= shutter_raw;
         sync_q2 <= sync_q1;
         press   <= 1'b0;
         if (sync_q2 == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
            cnt_q   <= '0;
            level_q <= sync_q2;
            press   <= sync_q2;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/camera_capture.sv
// Captures one camera frame per shutter press and writes RGB565 pixels to the frame buffer.
module camera_capture
   import camera_pkg::*;
#(
   parameter int unsigned H_RES    = H_RES_DEF,
   parameter int unsigned V_RES    = V_RES_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             shutter_raw,
   camera_capture_if.master bus,
   output logic             busy,
   output logic             frame_done,
   output logic             frame_err
);

   localparam int unsigned X_W = $clog2(H_RES + 1);
   localparam int unsigned Y_W = $clog2(V_RES + 1);

   cap_state_t        state_q, state_d;
   logic              vsync_q, href_q;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   rgb565_t           wr_data_q, wr_data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              press;
   logic              vsync_rise, vsync_fall, href_fall;

   shutter_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .shutter_raw (shutter_raw),
      .press       (press)
   );

   assign vsync_rise = bus.vsync & ~vsync_q;
   assign vsync_fall = ~bus.vsync & vsync_q;
   assign href_fall  = ~bus.href & href_q;

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_err   = err_q;

   // State, counters, pairing and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         vsync_q   <= 1'b0;
         href_q    <= 1'b0;
         phase_q   <= 1'b0;
         hi_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vsync_q   <= bus.vsync;
         href_q    <= bus.href;
         phase_q   <= phase_d;
         hi_q      <= hi_d;
         x_q       <= x_d;
         y_q       <= y_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state, byte pairing, line/pixel counting and frame status.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      hi_d      = hi_q;
      x_d       = x_q;
      y_d       = y_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = err_q;

      unique case (state_q)
         IDLE: begin
            if (press) begin
               state_d = ARMED;
               err_d   = 1'b0;
            end
         end
         ARMED: begin
            // Only a vsync pulse guarantees the capture begins on a frame boundary.
            if (bus.vsync) begin
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (vsync_fall) begin
               state_d = CAPTURE;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
               phase_d = 1'b0;
            end
         end
         CAPTURE: begin
            if (bus.href) begin
               if (!phase_q) begin
                  hi_d    = bus.d;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if ((x_q < X_W'(H_RES)) && (y_q < Y_W'(V_RES))) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = {hi_q, bus.d};
                     addr_d    = addr_q + ADDR_W'(1);
                  end
                  if (x_q < X_W'(H_RES)) begin
                     x_d = x_q + X_W'(1);
                  end
               end
            end else if (href_fall) begin
               // Line end: an odd trailing byte is dropped by clearing the phase.
               phase_d = 1'b0;
               x_d     = '0;
               if (x_q < X_W'(H_RES)) begin
                  err_d = 1'b1;
               end
               if (y_q < Y_W'(V_RES)) begin
                  y_d = y_q + Y_W'(1);
               end
            end
            // Uses y_d so a line ending on this same cycle is counted first.
            if (vsync_rise) begin
               state_d = DONE;
               done_d  = 1'b1;
               if (y_d != Y_W'(V_RES)) begin
                  err_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = is_busy(state_d);
   end

endmodule
